// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NREQ requesters.
// Grants bounded bursts of up to BULK_NUMBER words and watches for long full-stalls.
module fifo_wr_arbiter #(
  parameter int NREQ           = 4,
  parameter int DSIZE          = 8,
  parameter int BULK_NUMBER    = 10,
  parameter int WATCHDOG_LIMIT = 100
) (
  input  logic                      wclk,
  input  logic                      wrst_n,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ*DSIZE-1:0]     req_data,
  output logic [NREQ-1:0]           req_ready,
  output logic                      fifo_winc,
  output logic [DSIZE-1:0]          fifo_wdata,
  input  logic                      fifo_wfull,
  output logic [$clog2(NREQ)-1:0]   grant_id,
  output logic                      busy,
  output logic                      burst_done,
  output logic                      stall_err
);

  localparam int GW = $clog2(NREQ);
  localparam int CW = $clog2(BULK_NUMBER + 1);
  localparam int SW = $clog2(WATCHDOG_LIMIT + 1);

  localparam logic [GW-1:0] LAST_ID   = GW'(NREQ - 1);
  localparam logic [GW:0]   NREQ_EXT  = (GW + 1)'(NREQ);
  localparam logic [CW-1:0] LAST_BEAT = CW'(BULK_NUMBER - 1);
  localparam logic [SW-1:0] STALL_MAX = SW'(WATCHDOG_LIMIT);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_t;

  state_t          r_state;
  logic [GW-1:0]   r_rr_ptr;
  logic [GW-1:0]   r_grant;
  logic [CW-1:0]   r_count;
  logic [SW-1:0]   r_stall;
  logic            r_burst_done;
  logic            r_stall_err;

  logic            w_busy;
  logic            w_gvalid;
  logic            w_xfer;
  logic            w_stall;
  logic            w_end;
  logic            w_any;
  logic [GW-1:0]   w_next_ptr;
  logic [SW-1:0]   w_stall_inc;
  logic [2*NREQ-1:0] w_vv;
  logic [2*NREQ-1:0] w_vv_sh;
  logic [NREQ-1:0] w_rot;
  logic [GW-1:0]   w_off;
  logic [GW:0]     w_sum;
  logic [GW-1:0]   w_winner;

  assign w_busy      = (r_state == S_BURST);
  assign w_gvalid    = req_valid[r_grant];
  assign w_xfer      = w_busy & w_gvalid & ~fifo_wfull;
  assign w_stall     = w_busy & w_gvalid & fifo_wfull;
  assign w_end       = w_busy & (~w_gvalid | (w_xfer & (r_count == LAST_BEAT)));
  assign w_next_ptr  = (r_grant == LAST_ID) ? '0 : r_grant + 1'b1;
  assign w_stall_inc = (r_stall == STALL_MAX) ? r_stall : r_stall + 1'b1;
  assign w_any       = |req_valid;

  // Rotate requests so bit 0 is rr_ptr; the lowest set bit is the offset of the winner.
  assign w_vv    = {req_valid, req_valid};
  assign w_vv_sh = w_vv >> r_rr_ptr;
  assign w_rot   = w_vv_sh[NREQ-1:0];

  always_comb begin
    w_off = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (w_rot[k]) w_off = GW'(k);
    end
  end

  assign w_sum    = {1'b0, r_rr_ptr} + {1'b0, w_off};
  assign w_winner = (w_sum >= NREQ_EXT) ? GW'(w_sum - NREQ_EXT) : w_sum[GW-1:0];

  always_comb begin
    req_ready = '0;
    if (w_busy && !fifo_wfull) req_ready[r_grant] = 1'b1;
  end

  assign fifo_winc  = w_xfer;
  assign fifo_wdata = w_busy ? req_data[int'(r_grant)*DSIZE +: DSIZE] : '0;
  assign grant_id   = r_grant;
  assign busy       = w_busy;
  assign burst_done = r_burst_done;
  assign stall_err  = r_stall_err;

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      r_state      <= S_IDLE;
      r_rr_ptr     <= '0;
      r_grant      <= '0;
      r_count      <= '0;
      r_stall      <= '0;
      r_burst_done <= 1'b0;
      r_stall_err  <= 1'b0;
    end else begin
      r_burst_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_state <= S_BURST;
            r_grant <= w_winner;
            r_count <= '0;
            r_stall <= '0;
          end
        end
        S_BURST: begin
          if (w_end) begin
            r_state      <= S_IDLE;
            r_burst_done <= 1'b1;
            r_rr_ptr     <= w_next_ptr;
          end
          if (w_xfer) begin
            r_count <= r_count + 1'b1;
            r_stall <= '0;
          end else if (w_stall) begin
            // Counter saturates; the error flag is sticky until reset.
            r_stall <= w_stall_inc;
            if (w_stall_inc == STALL_MAX) r_stall_err <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized bench for fifo_wr_arbiter against a per-cycle behavioural model.
module tb_fifo_wr_arbiter;

  localparam int NREQ  = 4;
  localparam int DSIZE = 8;
  localparam int BULK  = 10;
  localparam int WDL   = 100;

  logic                  wclk = 1'b0;
  logic                  wrst_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*DSIZE-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic                  fifo_winc;
  logic [DSIZE-1:0]      fifo_wdata;
  logic                  fifo_wfull;
  logic [1:0]            grant_id;
  logic                  busy;
  logic                  burst_done;
  logic                  stall_err;

  fifo_wr_arbiter #(
    .NREQ(NREQ), .DSIZE(DSIZE), .BULK_NUMBER(BULK), .WATCHDOG_LIMIT(WDL)
  ) dut (
    .wclk(wclk), .wrst_n(wrst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .fifo_winc(fifo_winc), .fifo_wdata(fifo_wdata),
    .fifo_wfull(fifo_wfull), .grant_id(grant_id), .busy(busy),
    .burst_done(burst_done), .stall_err(stall_err)
  );

  always #5 wclk = ~wclk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model: owner -1 means no burst in progress.
  int m_owner, m_words, m_rr, m_stall;
  bit m_err, m_done;
  int seq [NREQ];
  int base2;
  bit arm_rst, rst_hit;

  task automatic model_reset();
    m_owner = -1; m_words = 0; m_rr = 0; m_stall = 0;
    m_err = 1'b0; m_done = 1'b0;
  endtask

  task automatic drive(input int mode, input int c);
    case (mode)
      0: begin req_valid = 4'b0001; fifo_wfull = 1'b0; end
      1: begin req_valid = 4'b1011; fifo_wfull = 1'b0; end
      2: begin
        for (int i = 0; i < NREQ; i++)
          if ($urandom_range(0, 9) < 3) req_valid[i] = ~req_valid[i];
        fifo_wfull = ($urandom_range(0, 9) == 0);
      end
      3: begin req_valid = 4'b1111; fifo_wfull = 1'b1; end
      4: begin req_valid = 4'b0100; fifo_wfull = (c >= 6 && c < 11); end
      default: begin
        if (c == 0) base2 = seq[2];
        req_valid = {1'b1, (seq[2] - base2) < 3, 2'b00};
        fifo_wfull = 1'b0;
      end
    endcase
    for (int i = 0; i < NREQ; i++) req_data[i*DSIZE +: DSIZE] = 8'(i * 32 + seq[i] % 32);
  endtask

  task automatic check_outputs();
    logic [3:0] e_ready;
    logic       e_winc;
    logic [7:0] e_data;
    e_ready = '0;
    e_winc  = 1'b0;
    e_data  = '0;
    if (m_owner >= 0) begin
      if (!fifo_wfull) e_ready = 4'(1 << m_owner);
      e_winc = req_valid[2'(m_owner)] && !fifo_wfull;
      e_data = 8'(m_owner * 32 + seq[m_owner] % 32);
    end
    check_val("busy", 32'(busy), 32'(m_owner >= 0));
    check_val("burst_done", 32'(burst_done), 32'(m_done));
    check_val("stall_err", 32'(stall_err), 32'(m_err));
    check_val("fifo_winc", 32'(fifo_winc), 32'(e_winc));
    check_val("req_ready", 32'(req_ready), 32'(e_ready));
    check_val("fifo_wdata", 32'(fifo_wdata), 32'(e_data));
    if (m_owner >= 0) check_val("grant_id", 32'(grant_id), 32'(m_owner));
  endtask

  task automatic model_step();
    bit found;
    if (m_owner < 0) begin
      m_done = 1'b0;
      found  = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
        int idx;
        idx = (m_rr + k) % NREQ;
        if (!found && req_valid[2'(idx)]) begin
          found = 1'b1;
          m_owner = idx;
        end
      end
      m_words = 0;
      m_stall = 0;
    end else if (!req_valid[2'(m_owner)]) begin
      m_done  = 1'b1;
      m_rr    = (m_owner + 1) % NREQ;
      m_owner = -1;
    end else if (fifo_wfull) begin
      m_done = 1'b0;
      if (m_stall < WDL) m_stall++;
      if (m_stall == WDL) m_err = 1'b1;
    end else begin
      seq[m_owner]++;
      m_words++;
      m_stall = 0;
      if (m_words == BULK) begin
        m_done  = 1'b1;
        m_rr    = (m_owner + 1) % NREQ;
        m_owner = -1;
      end else begin
        m_done = 1'b0;
      end
    end
  endtask

  task automatic pulse_reset();
    wrst_n = 1'b0;
    #1;
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_winc", 32'(fifo_winc), 32'd0);
    check_val("rst_ready", 32'(req_ready), 32'd0);
    arm_rst = 1'b0;
    rst_hit = 1'b1;
    @(posedge wclk);
    #1;
    wrst_n = 1'b1;
    model_reset();
  endtask

  // Each iteration starts 1 time unit after a rising edge.
  task automatic run(input int mode, input int n);
    for (int c = 0; c < n; c++) begin
      if (arm_rst && m_owner == 1 && m_words == 6) pulse_reset();
      drive(mode, c);
      #3;
      check_outputs();
      model_step();
      @(posedge wclk);
      #1;
    end
  endtask

  initial begin
    for (int i = 0; i < NREQ; i++) seq[i] = 0;
    base2      = 0;
    arm_rst    = 1'b0;
    rst_hit    = 1'b0;
    wrst_n     = 1'b0;
    req_valid  = 4'b1011;
    req_data   = '0;
    fifo_wfull = 1'b0;
    #2;
    check_val("init_busy", 32'(busy), 32'd0);
    check_val("init_winc", 32'(fifo_winc), 32'd0);
    check_val("init_ready", 32'(req_ready), 32'd0);
    check_val("init_done", 32'(burst_done), 32'd0);
    check_val("init_err", 32'(stall_err), 32'd0);
    check_val("init_grant", 32'(grant_id), 32'd0);
    @(posedge wclk);
    #1;
    wrst_n = 1'b1;
    req_valid = '0;
    model_reset();

    run(0, 30);
    run(1, 70);
    run(4, 20);
    run(5, 30);
    run(2, 300);
    arm_rst = 1'b1;
    run(1, 60);
    check_val("rst_mid_burst_hit", 32'(rst_hit), 32'd1);
    run(1, 20);
    run(3, 120);
    check_val("watchdog_set", 32'(stall_err), 32'd1);
    run(2, 200);
    run(1, 30);
    check_val("watchdog_sticky", 32'(stall_err), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin write-port arbiter that shares the write side of one async_fifo instance among NREQ requesters in the wclk domain.
- Grants one requester at a time for a bounded burst of up to BULK_NUMBER words.
- Drives fifo_winc/fifo_wdata directly and honours fifo_wfull.
- Flags a sticky error if a granted burst is blocked by a full FIFO for too long.

Parameters:
- NREQ, 4, number of requesters (2..8)
- DSIZE, 8, data width; must match the FIFO DSIZE
- BULK_NUMBER, 10, max words accepted per grant (>=1)
- WATCHDOG_LIMIT, 100, consecutive full-stall cycles in one burst before stall_err sets

Ports:
- wclk, in, 1, write-domain clock
- wrst_n, in, 1, asynchronous active-low reset
- req_valid, in, NREQ, per-requester data valid
- req_data, in, NREQ*DSIZE, requester i data at bits [i*DSIZE +: DSIZE]
- req_ready, out, NREQ, per-requester accept; a word transfers when valid&ready
- fifo_winc, out, 1, FIFO write increment
- fifo_wdata, out, DSIZE, FIFO write data
- fifo_wfull, in, 1, FIFO full
- grant_id, out, $clog2(NREQ), current owner; valid while busy=1
- busy, out, 1, a burst is in progress
- burst_done, out, 1, one-cycle pulse when a burst ends
- stall_err, out, 1, sticky watchdog flag

Behaviour:
- Reset (async, wrst_n=0): state=IDLE, rr_ptr=0, grant_id=0, beat count=0, stall counter=0, busy=0, burst_done=0, stall_err=0. fifo_winc=0 and req_ready=0 immediately, since both are gated by state.
- States are IDLE and BURST.
- IDLE: if any req_valid, select the first set bit searching from rr_ptr upward with wrap (rr_ptr, rr_ptr+1, …, NREQ-1, 0, …). The next cycle is BURST with grant_id = winner, count=0, stall counter=0. If no req_valid, stay in IDLE. A grant always costs exactly one idle cycle: the first transfer happens one cycle after req_valid is first seen.
- BURST, combinational outputs:
  - xfer = req_valid[g] & ~fifo_wfull, where g = grant_id.
  - req_ready[g] = ~fifo_wfull; req_ready of every other requester = 0.
  - fifo_winc = xfer.
  - fifo_wdata = req_data[g] in BURST; 0 in IDLE.
- BURST, on xfer: count increments.
- BURST ends (next state IDLE, burst_done=1 for one cycle, rr_ptr = g+1 mod NREQ) when either:
  - xfer occurs with count == BULK_NUMBER-1, or
  - req_valid[g]==0 in a BURST cycle. No transfer happens that cycle, and the burst counts as done even if count==0.
- Full stall: in BURST with req_valid[g]=1 and fifo_wfull=1:
  - No transfer; count and grant hold.
  - Stall counter increments, saturating at WATCHDOG_LIMIT.
  - stall_err sets when the counter reaches WATCHDOG_LIMIT and stays set until reset.
  - The stall counter clears on any xfer and on burst entry.
- Grant stickiness: the owner is never preempted mid-burst by other requesters.
- busy = (state==BURST).
- burst_done is registered: it is high in the IDLE cycle that follows the burst.
- Requester protocol: a requester must hold req_valid and req_data stable until it sees ready. A requester that deasserts valid loses its grant.
- Width rules:
  - count width is $clog2(BULK_NUMBER+1).
  - Stall counter width is $clog2(WATCHDOG_LIMIT+1).
  - rr_ptr wraps NREQ-1 -> 0, including for non-power-of-2 NREQ.
- Reset mid-burst: outputs drop asynchronously and any partial burst is abandoned. The FIFO sees no spurious winc.

Test Plan:
- Single requester: req_valid=4'b0001 held, 25 words, BULK_NUMBER=10, fifo never full -> bursts of 10, 10, 5 words in order. Each burst is separated by one IDLE cycle with burst_done=1. The FIFO receives all 25 words in order.
- Round-robin: req_valid=4'b1011 continuously -> grant_id sequence 0,1,3,0,1,3…, each burst exactly 10 words. Requester 2 never gets req_ready.
- Early release: requester 2 granted, sends 3 words, then drops valid -> burst ends after 3 words, burst_done pulses, rr_ptr=3, and the next grant goes to requester 3 if it is requesting.
- Full backpressure: fifo_wfull=1 for 5 cycles mid-burst after word 4 -> fifo_winc=0 and req_ready[g]=0 for those 5 cycles. The burst resumes with the same grant and ends after word 10. stall_err stays 0.
- Watchdog: WATCHDOG_LIMIT=100, fifo_wfull stuck at 1 with the owner valid -> stall_err rises after 100 stall cycles and stays 1 after fifo_wfull clears and traffic resumes. Only wrst_n clears it.
- Reset mid-burst: wrst_n pulsed low after word 6 of a burst by requester 1 -> fifo_winc, busy and req_ready go 0 immediately. After release, arbitration restarts from rr_ptr=0.
